// File: rtl/debug_pkg.sv
// Shared definitions for the debug telemetry block: sequencer states and
// the ASCII codes used to build "CHk:XXXX\r\n" lines.
package debug_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [7:0] ASCII_C       = 8'h43;
    localparam logic [7:0] ASCII_H       = 8'h48;
    localparam logic [7:0] ASCII_COLON   = 8'h3A;
    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_LF      = 8'h0A;
    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] ASCII_A       = 8'h41;
    localparam logic [7:0] ASCII_LOWER_H = 8'h68;

endpackage

// File: rtl/hex_to_ascii.sv
// Combinational nibble to uppercase hexadecimal ASCII character.
module hex_to_ascii
    import debug_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii = ASCII_ZERO + {4'd0, nibble};
        end else begin
            ascii = ASCII_A + {4'd0, nibble} - 8'd10;
        end
    end

endmodule

// File: rtl/debug_telemetry.sv
// Snapshots the channel inputs on a timer or UART command and streams them
// as ASCII lines to a UART transmitter, one byte every other cycle at most.
module debug_telemetry
    import debug_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 16,
    parameter int OVF_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tmr,
    input  logic [NUM_CH*DATA_W-1:0]   ch_data,
    input  logic [7:0]                 rx_data,
    input  logic                       new_rx_data,
    input  logic                       tx_busy,
    output logic [7:0]                 tx_data,
    output logic                       new_tx_data,
    output logic                       busy,
    output logic [OVF_W-1:0]           ovf_cnt
);

    localparam int NUM_NIB  = DATA_W / 4;
    localparam int LINE_LEN = 6 + NUM_NIB;

    localparam logic [3:0] LAST_BYTE = 4'(LINE_LEN - 1);
    localparam logic [3:0] CR_BYTE   = 4'(LINE_LEN - 2);
    localparam logic [2:0] LAST_CH   = 3'(NUM_CH - 1);
    localparam logic [7:0] DIGIT_END = ASCII_ZERO + 8'(NUM_CH);

    state_t state;
    state_t next_state;

    logic [NUM_CH*DATA_W-1:0] snapshot;
    logic [2:0]               ch_idx;
    logic [2:0]               ch_last;
    logic [3:0]               byte_idx;
    logic                     last_sent;

    logic       rx_all;
    logic       rx_single;
    logic       rx_req;
    logic [2:0] rx_ch;
    logic       accept;
    logic       send;
    logic       finish;

    logic [1:0]       drops;
    logic [OVF_W:0]   ovf_sum;
    logic [OVF_W-1:0] ovf_next;

    logic [DATA_W-1:0] cur_word;
    logic [3:0]        nib_sel;
    logic [3:0]        nibble;
    logic [7:0]        hex_char;
    logic [7:0]        cur_byte;

    // Digits '0'..'7' carry the channel number in their low three bits.
    always_comb begin
        rx_all    = new_rx_data && (rx_data == ASCII_LOWER_H);
        rx_single = new_rx_data && (rx_data >= ASCII_ZERO) && (rx_data < DIGIT_END);
        rx_req    = rx_all || rx_single;
        rx_ch     = rx_data[2:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        send       = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_req || tmr) begin
                    accept     = 1'b1;
                    next_state = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!tx_busy) begin
                    send       = 1'b1;
                    next_state = ST_GAP;
                end
            end
            ST_GAP: begin
                if (last_sent) begin
                    finish     = 1'b1;
                    next_state = ST_IDLE;
                end else begin
                    next_state = ST_SEND;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // In IDLE only the timer loses to a simultaneous command; otherwise every request is dropped.
    always_comb begin
        drops = 2'd0;
        if (state == ST_IDLE) begin
            if (rx_req && tmr) begin
                drops = 2'd1;
            end
        end else begin
            drops = {1'b0, rx_req} + {1'b0, tmr};
        end
        ovf_sum  = {1'b0, ovf_cnt} + (OVF_W+1)'(drops);
        ovf_next = ovf_sum[OVF_W] ? '1 : ovf_sum[OVF_W-1:0];
    end

    always_comb begin
        cur_word = DATA_W'(snapshot >> (ch_idx * DATA_W));
        nib_sel  = 4'(NUM_NIB - 1) - (byte_idx - 4'd4);
        nibble   = 4'(cur_word >> {nib_sel, 2'b00});
    end

    hex_to_ascii u_hex (
        .nibble (nibble),
        .ascii  (hex_char)
    );

    always_comb begin
        if (byte_idx == 4'd0) begin
            cur_byte = ASCII_C;
        end else if (byte_idx == 4'd1) begin
            cur_byte = ASCII_H;
        end else if (byte_idx == 4'd2) begin
            cur_byte = ASCII_ZERO + {5'd0, ch_idx};
        end else if (byte_idx == 4'd3) begin
            cur_byte = ASCII_COLON;
        end else if (byte_idx == CR_BYTE) begin
            cur_byte = ASCII_CR;
        end else if (byte_idx == LAST_BYTE) begin
            cur_byte = ASCII_LF;
        end else begin
            cur_byte = hex_char;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snapshot    <= '0;
            ch_idx      <= 3'd0;
            ch_last     <= 3'd0;
            byte_idx    <= 4'd0;
            last_sent   <= 1'b0;
            tx_data     <= 8'h00;
            new_tx_data <= 1'b0;
            ovf_cnt     <= '0;
        end else begin
            new_tx_data <= send;
            ovf_cnt     <= ovf_next;
            if (accept) begin
                snapshot  <= ch_data;
                byte_idx  <= 4'd0;
                last_sent <= 1'b0;
                if (rx_single) begin
                    ch_idx  <= rx_ch;
                    ch_last <= rx_ch;
                end else begin
                    ch_idx  <= 3'd0;
                    ch_last <= LAST_CH;
                end
            end
            if (send) begin
                tx_data <= cur_byte;
                if (byte_idx == LAST_BYTE) begin
                    byte_idx <= 4'd0;
                    if (ch_idx == ch_last) begin
                        last_sent <= 1'b1;
                    end else begin
                        ch_idx <= ch_idx + 3'd1;
                    end
                end else begin
                    byte_idx <= byte_idx + 4'd1;
                end
            end
            if (finish) begin
                last_sent <= 1'b0;
                ch_idx    <= 3'd0;
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_debug_telemetry.sv
// Directed and randomized checks of debug_telemetry against a string-level
// model of the expected UART byte stream.
module tb_debug_telemetry;

    localparam int NUM_CH = 2;
    localparam int DATA_W = 16;
    localparam int OVF_W  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst_n;
    logic                     tmr;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [7:0]               rx_data;
    logic                     new_rx_data;
    logic                     tx_busy;
    logic [7:0]               tx_data;
    logic                     new_tx_data;
    logic                     busy;
    logic [OVF_W-1:0]         ovf_cnt;

    logic             tmr_w;
    logic [31:0]      ch_data_w;
    logic [7:0]       rx_data_w;
    logic             new_rx_data_w;
    logic             tx_busy_w;
    logic [7:0]       tx_data_w;
    logic             new_tx_data_w;
    logic             busy_w;
    logic [OVF_W-1:0] ovf_cnt_w;

    debug_telemetry #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .OVF_W(OVF_W)) dut (
        .clk(clk), .rst_n(rst_n), .tmr(tmr), .ch_data(ch_data),
        .rx_data(rx_data), .new_rx_data(new_rx_data), .tx_busy(tx_busy),
        .tx_data(tx_data), .new_tx_data(new_tx_data), .busy(busy), .ovf_cnt(ovf_cnt)
    );

    debug_telemetry #(.NUM_CH(1), .DATA_W(32), .OVF_W(OVF_W)) dut_wide (
        .clk(clk), .rst_n(rst_n), .tmr(tmr_w), .ch_data(ch_data_w),
        .rx_data(rx_data_w), .new_rx_data(new_rx_data_w), .tx_busy(tx_busy_w),
        .tx_data(tx_data_w), .new_tx_data(new_tx_data_w), .busy(busy_w), .ovf_cnt(ovf_cnt_w)
    );

    int checks = 0;
    int errors = 0;

    int   cyc = 0;
    logic [7:0] got_q[$];
    int         got_cyc[$];
    logic [7:0] got_w[$];
    int   proto_bad = 0;
    logic prev_strobe = 1'b0;
    logic prev_busy = 1'b0;

    string hex_digits = "0123456789ABCDEF";

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every strobe; a strobe right after another, or launched while the
    // transmitter reported busy, is a protocol violation.
    always @(negedge clk) begin
        if (new_tx_data) begin
            got_q.push_back(tx_data);
            got_cyc.push_back(cyc);
            if (prev_strobe || prev_busy) proto_bad++;
        end
        prev_strobe = new_tx_data;
        prev_busy   = tx_busy;
        if (new_tx_data_w) got_w.push_back(tx_data_w);
    end

    function automatic string hex_str(input logic [31:0] v, input int nd);
        string s = "";
        for (int i = nd - 1; i >= 0; i--) begin
            int d = int'((v >> (4 * i)) & 32'hF);
            s = {s, hex_digits.substr(d, d)};
        end
        return s;
    endfunction

    function automatic string frame16(input int first, input int last,
                                      input logic [NUM_CH*DATA_W-1:0] data);
        string s = "";
        for (int k = first; k <= last; k++) begin
            s = {s, $sformatf("CH%0d:%s\r\n", k, hex_str(32'(data[k*DATA_W +: DATA_W]), 4))};
        end
        return s;
    endfunction

    function automatic string got_str(input int from);
        string s = "";
        for (int i = from; i < got_q.size(); i++) s = $sformatf("%s%c", s, got_q[i]);
        return s;
    endfunction

    function automatic string got_w_str(input int from);
        string s = "";
        for (int i = from; i < got_w.size(); i++) s = $sformatf("%s%c", s, got_w[i]);
        return s;
    endfunction

    function automatic string visible(input string s);
        string r = "";
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == 8'h0D) r = {r, "\\r"};
            else if (s[i] == 8'h0A) r = {r, "\\n"};
            else r = $sformatf("%s%c", r, s[i]);
        end
        return r;
    endfunction

    function automatic int sat_add(input int a, input int b);
        return (a + b > 255) ? 255 : a + b;
    endfunction

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_frame(input string tag, input string obs, input string exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=\"%s\" expected=\"%s\"", tag, visible(obs), visible(exp));
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic t, input logic rv, input logic [7:0] rb);
        tmr = t;
        new_rx_data = rv;
        rx_data = rb;
        tick(1);
        tmr = 1'b0;
        new_rx_data = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick(1);
            n++;
        end
        check_output({tag, " idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int base;
        int c0;
        int n;
        int ovf_exp;
        int n5;
        logic [7:0] pick;

        rst_n = 1'b0; tmr = 1'b0; ch_data = '0; rx_data = 8'h00;
        new_rx_data = 1'b0; tx_busy = 1'b0;
        tmr_w = 1'b0; ch_data_w = '0; rx_data_w = 8'h00; new_rx_data_w = 1'b0; tx_busy_w = 1'b0;
        ovf_exp = 0;
        tick(3);
        check_output("reset tx_data", 64'(tx_data), 64'h00);
        check_output("reset new_tx_data", 64'(new_tx_data), 64'd0);
        check_output("reset busy", 64'(busy), 64'd0);
        check_output("reset ovf_cnt", 64'(ovf_cnt), 64'd0);
        check_output("reset busy wide", 64'(busy_w), 64'd0);
        rst_n = 1'b1;
        tick(2);

        $display("[TB] all-channel timer frame");
        ch_data = {16'h0012, 16'hBEEF};
        base = got_q.size();
        c0 = cyc;
        apply_stimulus(1'b1, 1'b0, 8'h00);
        wait_idle("tmr frame", 200);
        check_frame("tmr frame bytes", got_str(base), "CH0:BEEF\r\nCH1:0012\r\n");
        check_output("tmr frame count", 64'(got_q.size() - base), 64'd20);
        n = (got_cyc.size() > base) ? got_cyc[base] - c0 : -1;
        check_output("first strobe latency", 64'(n >= 2 && n <= 4), 64'd1);
        check_output("tmr frame ovf", 64'(ovf_cnt), 64'(ovf_exp));

        $display("[TB] single-channel and ignored commands");
        ch_data = {16'hA5C3, 16'h7777};
        base = got_q.size();
        apply_stimulus(1'b0, 1'b1, "1");
        wait_idle("rx 1", 200);
        check_frame("rx 1 bytes", got_str(base), "CH1:A5C3\r\n");
        base = got_q.size();
        apply_stimulus(1'b0, 1'b1, "7");
        apply_stimulus(1'b0, 1'b1, "2");
        apply_stimulus(1'b0, 1'b1, "x");
        tick(10);
        check_output("ignored rx bytes", 64'(got_q.size() - base), 64'd0);
        check_output("ignored rx busy", 64'(busy), 64'd0);
        check_output("ignored rx ovf", 64'(ovf_cnt), 64'(ovf_exp));
        base = got_q.size();
        apply_stimulus(1'b0, 1'b1, "h");
        wait_idle("rx h", 200);
        check_frame("rx h bytes", got_str(base), "CH0:7777\r\nCH1:A5C3\r\n");

        $display("[TB] back-pressure");
        ch_data = {16'h0F1E, 16'h2D3C};
        base = got_q.size();
        apply_stimulus(1'b1, 1'b0, 8'h00);
        n = 0;
        while (!new_tx_data && n < 20) begin
            tick(1);
            n++;
        end
        check_output("bp first strobe seen", 64'(new_tx_data), 64'd1);
        tx_busy = 1'b1;
        ch_data = {$urandom, $urandom};
        tick(50);
        check_output("bp bytes during hold", 64'(got_q.size() - base), 64'd1);
        tx_busy = 1'b0;
        wait_idle("bp", 200);
        check_frame("bp bytes", got_str(base), "CH0:2D3C\r\nCH1:0F1E\r\n");

        $display("[TB] overrun saturation");
        ch_data = {16'h5A5A, 16'hC0DE};
        base = got_q.size();
        apply_stimulus(1'b1, 1'b0, 8'h00);
        tx_busy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tmr = 1'b1;
            tick(1);
            tmr = 1'b0;
            tick(1);
        end
        ovf_exp = sat_add(ovf_exp, 300);
        check_output("ovf saturated", 64'(ovf_cnt), 64'(ovf_exp));
        tx_busy = 1'b0;
        wait_idle("overrun", 200);
        check_frame("overrun bytes", got_str(base), "CH0:C0DE\r\nCH1:5A5A\r\n");
        check_output("ovf after frame", 64'(ovf_cnt), 64'hFF);

        rst_n = 1'b0;
        tick(2);
        check_output("reset2 ovf", 64'(ovf_cnt), 64'd0);
        rst_n = 1'b1;
        tick(1);
        ovf_exp = 0;

        $display("[TB] simultaneous timer and command");
        ch_data = {16'h1111, 16'h2222};
        base = got_q.size();
        apply_stimulus(1'b1, 1'b1, "h");
        ovf_exp = sat_add(ovf_exp, 1);
        wait_idle("tmr+h", 200);
        check_output("tmr+h ovf", 64'(ovf_cnt), 64'(ovf_exp));
        check_frame("tmr+h bytes", got_str(base), "CH0:2222\r\nCH1:1111\r\n");
        base = got_q.size();
        apply_stimulus(1'b1, 1'b1, "0");
        ovf_exp = sat_add(ovf_exp, 1);
        wait_idle("tmr+0", 200);
        check_output("tmr+0 ovf", 64'(ovf_cnt), 64'(ovf_exp));
        check_frame("tmr+0 bytes", got_str(base), "CH0:2222\r\n");

        $display("[TB] snapshot and mid-frame reset");
        ch_data = {16'h9876, 16'h1234};
        base = got_q.size();
        apply_stimulus(1'b1, 1'b0, 8'h00);
        ch_data[15:0] = 16'hFFFF;
        wait_idle("snapshot", 200);
        check_frame("snapshot bytes", got_str(base), "CH0:1234\r\nCH1:9876\r\n");
        base = got_q.size();
        apply_stimulus(1'b1, 1'b0, 8'h00);
        n = 0;
        while (got_q.size() - base < 5 && n < 100) begin
            tick(1);
            n++;
        end
        check_output("bytes before reset", 64'(got_q.size() - base), 64'd5);
        rst_n = 1'b0;
        tick(1);
        check_output("midreset tx_data", 64'(tx_data), 64'h00);
        check_output("midreset new_tx_data", 64'(new_tx_data), 64'd0);
        check_output("midreset busy", 64'(busy), 64'd0);
        check_output("midreset ovf", 64'(ovf_cnt), 64'd0);
        ovf_exp = 0;
        n5 = got_q.size();
        rst_n = 1'b1;
        tick(30);
        check_output("silence after reset", 64'(got_q.size() - n5), 64'd0);
        check_output("idle after reset", 64'(busy), 64'd0);
        base = got_q.size();
        apply_stimulus(1'b1, 1'b0, 8'h00);
        wait_idle("after reset", 200);
        check_frame("after reset bytes", got_str(base), "CH0:FFFF\r\nCH1:9876\r\n");

        $display("[TB] randomized frames");
        for (int it = 0; it < 12; it++) begin
            logic [NUM_CH*DATA_W-1:0] snap;
            string exp;
            int kind;
            int k;
            int exp_len;
            snap = {16'($urandom), 16'($urandom)};
            ch_data = snap;
            kind = $urandom_range(0, 3);
            k = $urandom_range(0, NUM_CH - 1);
            base = got_q.size();
            case (kind)
                0: begin apply_stimulus(1'b1, 1'b0, 8'h00); exp = frame16(0, NUM_CH - 1, snap); end
                1: begin apply_stimulus(1'b0, 1'b1, "h"); exp = frame16(0, NUM_CH - 1, snap); end
                2: begin apply_stimulus(1'b0, 1'b1, 8'(8'h30 + k)); exp = frame16(k, k, snap); end
                default: begin
                    apply_stimulus(1'b1, 1'b1, 8'(8'h30 + k));
                    exp = frame16(k, k, snap);
                    ovf_exp = sat_add(ovf_exp, 1);
                end
            endcase
            exp_len = exp.len();
            n = 0;
            while (busy && n < 3000) begin
                tx_busy = ($urandom_range(0, 3) == 0);
                ch_data = {$urandom, $urandom};
                if (got_q.size() - base >= 1 && got_q.size() - base < exp_len
                    && $urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 1) == 0) begin
                        tmr = 1'b1;
                        ovf_exp = sat_add(ovf_exp, 1);
                    end else begin
                        case ($urandom_range(0, 5))
                            0: pick = "h";
                            1: pick = "0";
                            2: pick = "1";
                            3: pick = "2";
                            4: pick = "9";
                            default: pick = "x";
                        endcase
                        new_rx_data = 1'b1;
                        rx_data = pick;
                        if (pick == "h" || pick == "0" || pick == "1") ovf_exp = sat_add(ovf_exp, 1);
                    end
                end
                tick(1);
                tmr = 1'b0;
                new_rx_data = 1'b0;
                rx_data = 8'h00;
                n++;
            end
            tx_busy = 1'b0;
            check_output($sformatf("rand%0d idle", it), 64'(busy), 64'd0);
            check_frame($sformatf("rand%0d bytes", it), got_str(base), exp);
            check_output($sformatf("rand%0d ovf", it), 64'(ovf_cnt), 64'(ovf_exp));
        end

        $display("[TB] 32-bit single channel instance");
        ch_data_w = 32'hDEADBEEF;
        base = got_w.size();
        tmr_w = 1'b1;
        tick(1);
        tmr_w = 1'b0;
        ch_data_w = 32'h0;
        n = 0;
        while (busy_w && n < 200) begin
            tick(1);
            n++;
        end
        check_output("wide idle", 64'(busy_w), 64'd0);
        check_frame("wide bytes", got_w_str(base), "CH0:DEADBEEF\r\n");
        check_output("wide count", 64'(got_w.size() - base), 64'd14);
        check_output("wide ovf", 64'(ovf_cnt_w), 64'd0);

        check_output("strobe protocol violations", 64'(proto_bad), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
